// File: rtl/led_frame_sched.sv
// led_frame_sched: streams one LED frame from frame memory to the serializer, one byte per bit slot.
// Each frame starts with RESET_SLOTS all-zero slots (the LED latch/reset gap).
// Ports:
//   clk_200, ar (async, active-low)  clock and reset
//   start, slot_tick                 frame request pulse, serializer slot pulse
//   mem_rd, mem_addr, mem_data       frame-memory read port (data valid the cycle after mem_rd)
//   data_out                         byte to serializer data_in (bit n = strip n)
//   busy, frame_done, underrun       status: frame active, end-of-frame pulse, sticky late-data flag
// Build option: define SCHED_CONTINUOUS_EN to repeat frames back-to-back after the first start.
module led_frame_sched #(
  parameter int NUM_LEDS     = 64,
  parameter int BITS_PER_LED = 24,
  parameter int RESET_SLOTS  = 400,
  parameter int ADDR_W       = 11
) (
  input  logic              clk_200,
  input  logic              ar,
  input  logic              start,
  input  logic              slot_tick,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        data_out,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int LAST = NUM_LEDS * BITS_PER_LED - 1;
  localparam int GW   = $clog2(RESET_SLOTS + 1);
  typedef enum logic [1:0] {IDLE, GAP, SEND, FLUSH} state_t;
  state_t state, state_nx;
  logic [GW-1:0]     gap_cnt;
  logic [ADDR_W-1:0] slot_cnt;
  logic [7:0]        pre_buf;
  logic              pre_vld, rd_d, drop_d;
  logic              gap_last, last_slot, ur_tick, capture;
  // A slot that underruns owns the read issued by the previous tick. If that read is
  // arriving on this edge it is discarded now; if it is still one cycle out it is
  // tagged (drop_d) so it is discarded on arrival instead of landing in the next slot.
  always_comb begin
    gap_last  = gap_cnt == GW'(RESET_SLOTS - 1);
    last_slot = slot_cnt == ADDR_W'(LAST);
    ur_tick   = (state == SEND) && slot_tick && !pre_vld;
    capture   = rd_d && !drop_d && !(ur_tick && !mem_rd);
    state_nx  = state;
    case (state)
      IDLE:  state_nx = start ? GAP : IDLE;
      GAP:   state_nx = (slot_tick && gap_last) ? SEND : GAP;
      SEND:  state_nx = (slot_tick && last_slot) ? FLUSH : SEND;
`ifdef SCHED_CONTINUOUS_EN
      FLUSH: state_nx = slot_tick ? GAP : FLUSH;
`else
      FLUSH: state_nx = slot_tick ? IDLE : FLUSH;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_200 or negedge ar)
    if (!ar) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_200 or negedge ar) begin
    if (!ar) begin
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      data_out   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      gap_cnt    <= '0;
      slot_cnt   <= '0;
      pre_buf    <= 8'h00;
      pre_vld    <= 1'b0;
      rd_d       <= 1'b0;
      drop_d     <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      frame_done <= 1'b0;
      rd_d       <= mem_rd;
      drop_d     <= mem_rd && ur_tick;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          underrun <= 1'b0;
          gap_cnt  <= '0;
        end
        GAP: if (slot_tick) begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last) begin
            mem_rd   <= 1'b1;
            mem_addr <= '0;
            slot_cnt <= '0;
          end
        end
        SEND: if (slot_tick) begin
          data_out <= pre_vld ? pre_buf : 8'h00;
          pre_vld  <= 1'b0;
          underrun <= underrun | ~pre_vld;
          slot_cnt <= slot_cnt + 1'b1;
          if (!last_slot) begin
            mem_rd   <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        FLUSH: if (slot_tick) begin
          data_out   <= 8'h00;
          frame_done <= 1'b1;
          gap_cnt    <= '0;
`ifndef SCHED_CONTINUOUS_EN
          busy       <= 1'b0;
`endif
        end
        default: ;
      endcase
      if (capture) begin
        pre_buf <= mem_data;
        pre_vld <= 1'b1;
      end
    end
  end
endmodule
